mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the instruction-fetch requester (IF) and
//  the data requester (load/store stage). Latches 1-cycle request pulses, arbitrates, and

---
 rtl/mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between the instruction-fetch
// requester and the load/store requester. Each requester owns one pending
// slot that captures its 1-cycle request pulse. One memory transaction runs
// at a time (IDLE -> ISSUE -> WAIT -> RESP). Each response goes back to its
// owner as a 1-cycle valid pulse.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on a
// tie. Without it the data slot always wins a tie.
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_inst_req_valid/_addr        fetch request pulse and address
//   o_inst_resp_valid/_data       fetch response pulse and instruction
//   i_data_req_valid/_we/_addr/_wdata   load/store request pulse and fields
//   o_data_resp_valid/_rdata      load data / store ack (rdata=0 for stores)
//   o_m_valid/_we/_addr/_wdata    memory request pulse and held fields
//   i_m_valid/_rdata              memory response pulse and read data
//   o_busy                        transaction active or a slot pending
//   o_err                         sticky protocol error (dropped request or
//                                 unexpected memory response)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inst_req_valid,
    input  logic [ADDR_W-1:0] i_inst_req_addr,
    output logic              o_inst_resp_valid,
    output logic [31:0]       o_inst_resp_data,
    input  logic              i_data_req_valid,
    input  logic              i_data_req_we,
    input  logic [ADDR_W-1:0] i_data_req_addr,
    input  logic [DATA_W-1:0] i_data_req_wdata,
    output logic              o_data_resp_valid,
    output logic [DATA_W-1:0] o_data_resp_rdata,
    output logic              o_m_valid,
    output logic              o_m_we,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    input  logic              i_m_valid,
    input  logic [DATA_W-1:0] i_m_rdata,
    output logic              o_busy,
    output logic              o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Pending slots
    logic              inst_full_reg, inst_full_next;
    logic [ADDR_W-1:0] inst_addr_reg, inst_addr_next;
    logic              data_full_reg, data_full_next;
    logic              data_we_reg, data_we_next;
    logic [ADDR_W-1:0] data_addr_reg, data_addr_next;
    logic [DATA_W-1:0] data_wdata_reg, data_wdata_next;

    // Owner of the current transaction: 1 = data, 0 = instruction
    logic grant_reg, grant_next;

    // Registered outputs
    logic              m_valid_reg, m_valid_next;
    logic              m_we_reg, m_we_next;
    logic [ADDR_W-1:0] m_addr_reg, m_addr_next;
    logic [DATA_W-1:0] m_wdata_reg, m_wdata_next;
    logic              inst_resp_valid_reg, inst_resp_valid_next;
    logic [31:0]       inst_resp_data_reg, inst_resp_data_next;
    logic              data_resp_valid_reg, data_resp_valid_next;
    logic [DATA_W-1:0] data_resp_rdata_reg, data_resp_rdata_next;
    logic              err_reg, err_next;

    logic issue;
    logic pick_data;
    logic inst_inflight, data_inflight;
    logic inst_drop, data_drop;
    logic mem_resp;

    assign issue = (state_reg == IDLE) && (inst_full_reg || data_full_reg);

`ifdef MEM_ARB_RR_EN
    // 1 = data was granted last. Reset value (0) makes the first tie go to data.
    logic last_grant_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant_reg <= 1'b0;
        end else if (issue) begin
            last_grant_reg <= pick_data;
        end
    end

    // On a tie the requester that was not granted last wins.
    assign pick_data = data_full_reg && (!inst_full_reg || !last_grant_reg);
`else
    assign pick_data = data_full_reg;
`endif

    // A transaction is in flight from issue until the memory responds; a pulse
    // during the response cycle is accepted so the slot can be refilled early.
    assign inst_inflight = ((state_reg == ISSUE) || (state_reg == WAIT)) && !grant_reg;
    assign data_inflight = ((state_reg == ISSUE) || (state_reg == WAIT)) && grant_reg;

    assign inst_drop = i_inst_req_valid && (inst_full_reg || inst_inflight);
    assign data_drop = i_data_req_valid && (data_full_reg || data_inflight);

    assign mem_resp = (state_reg == WAIT) && i_m_valid;

    // ---------------------------------------------------------------- state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (issue) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (i_m_valid) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------- outputs and datapath next
    always_comb begin
        inst_full_next       = inst_full_reg;
        inst_addr_next       = inst_addr_reg;
        data_full_next       = data_full_reg;
        data_we_next         = data_we_reg;
        data_addr_next       = data_addr_reg;
        data_wdata_next      = data_wdata_reg;
        grant_next           = grant_reg;
        m_we_next            = m_we_reg;
        m_addr_next          = m_addr_reg;
        m_wdata_next         = m_wdata_reg;
        inst_resp_data_next  = inst_resp_data_reg;
        data_resp_rdata_next = data_resp_rdata_reg;

        m_valid_next         = (state_next == ISSUE);
        inst_resp_valid_next = mem_resp && !grant_reg;
        data_resp_valid_next = mem_resp && grant_reg;
        err_next             = err_reg || inst_drop || data_drop ||
                               (i_m_valid && (state_reg != WAIT));

        // Issue frees the winning slot and latches the memory request fields.
        if (issue) begin
            grant_next = pick_data;
            if (pick_data) begin
                data_full_next = 1'b0;
                m_we_next      = data_we_reg;
                m_addr_next    = data_addr_reg;
                m_wdata_next   = data_wdata_reg;
            end else begin
                inst_full_next = 1'b0;
                m_we_next      = 1'b0;
                m_addr_next    = inst_addr_reg;
                m_wdata_next   = '0;
            end
        end

        // Capture never collides with the free above: capture needs an empty slot.
        if (i_inst_req_valid && !inst_drop) begin
            inst_full_next = 1'b1;
            inst_addr_next = i_inst_req_addr;
        end
        if (i_data_req_valid && !data_drop) begin
            data_full_next  = 1'b1;
            data_we_next    = i_data_req_we;
            data_addr_next  = i_data_req_addr;
            data_wdata_next = i_data_req_wdata;
        end

        if (mem_resp && !grant_reg) begin
            inst_resp_data_next = i_m_rdata[31:0];
        end
        // m_we_reg still holds the owner's write enable during WAIT.
        if (mem_resp && grant_reg) begin
            data_resp_rdata_next = m_we_reg ? '0 : i_m_rdata;
        end
    end

    // ------------------------------------------------------ datapath regs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inst_full_reg       <= 1'b0;
            inst_addr_reg       <= '0;
            data_full_reg       <= 1'b0;
            data_we_reg         <= 1'b0;
            data_addr_reg       <= '0;
            data_wdata_reg      <= '0;
            grant_reg           <= 1'b0;
            m_valid_reg         <= 1'b0;
            m_we_reg            <= 1'b0;
            m_addr_reg          <= '0;
            m_wdata_reg         <= '0;
            inst_resp_valid_reg <= 1'b0;
            inst_resp_data_reg  <= '0;
            data_resp_valid_reg <= 1'b0;
            data_resp_rdata_reg <= '0;
            err_reg             <= 1'b0;
        end else begin
            inst_full_reg       <= inst_full_next;
            inst_addr_reg       <= inst_addr_next;
            data_full_reg       <= data_full_next;
            data_we_reg         <= data_we_next;
            data_addr_reg       <= data_addr_next;
            data_wdata_reg      <= data_wdata_next;
            grant_reg           <= grant_next;
            m_valid_reg         <= m_valid_next;
            m_we_reg            <= m_we_next;
            m_addr_reg          <= m_addr_next;
            m_wdata_reg         <= m_wdata_next;
            inst_resp_valid_reg <= inst_resp_valid_next;
            inst_resp_data_reg  <= inst_resp_data_next;
            data_resp_valid_reg <= data_resp_valid_next;
            data_resp_rdata_reg <= data_resp_rdata_next;
            err_reg             <= err_next;
        end
    end

    assign o_m_valid         = m_valid_reg;
    assign o_m_we            = m_we_reg;
    assign o_m_addr          = m_addr_reg;
    assign o_m_wdata         = m_wdata_reg;
    assign o_inst_resp_valid = inst_resp_valid_reg;
    assign o_inst_resp_data  = inst_resp_data_reg;
    assign o_data_resp_valid = data_resp_valid_reg;
    assign o_data_resp_rdata = data_resp_rdata_reg;
    assign o_err             = err_reg;
    // Decoded only from registers, so it is glitch-free.
    assign o_busy            = (state_reg != IDLE) || inst_full_reg || data_full_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a per-cycle vector table covering
// fetch, store and load transactions, then hand-written sequences for
// arbitration ties, dropped requests and reset in the middle of a transaction.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_v = 1'b0;
    logic [63:0] inst_a = '0;
    logic        inst_rv;
    logic [31:0] inst_rd;
    logic        data_v = 1'b0;
    logic        data_we = 1'b0;
    logic [63:0] data_a = '0;
    logic [63:0] data_w = '0;
    logic        data_rv;
    logic [63:0] data_rd;
    logic        m_valid;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic        m_v = 1'b0;
    logic [63:0] m_rdata = '0;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_inst_req_valid(inst_v),
        .i_inst_req_addr(inst_a),
        .o_inst_resp_valid(inst_rv),
        .o_inst_resp_data(inst_rd),
        .i_data_req_valid(data_v),
        .i_data_req_we(data_we),
        .i_data_req_addr(data_a),
        .i_data_req_wdata(data_w),
        .o_data_resp_valid(data_rv),
        .o_data_resp_rdata(data_rd),
        .o_m_valid(m_valid),
        .o_m_we(m_we),
        .o_m_addr(m_addr),
        .o_m_wdata(m_wdata),
        .i_m_valid(m_v),
        .i_m_rdata(m_rdata),
        .o_busy(busy),
        .o_err(err)
    );

    typedef struct {
        logic        iv;
        logic [63:0] ia;
        logic        dv;
        logic        dwe;
        logic [63:0] da;
        logic [63:0] dw;
        logic        mv;
        logic [63:0] mr;
        logic        e_mv;
        logic        e_mwe;
        logic [63:0] e_ma;
        logic [63:0] e_mw;
        logic        e_irv;
        logic [31:0] e_ird;
        logic        e_drv;
        logic [63:0] e_drd;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
        chk({tag, "_m_we"}, {63'd0, m_we}, 64'd0);
        chk({tag, "_m_addr"}, m_addr, 64'd0);
        chk({tag, "_m_wdata"}, m_wdata, 64'd0);
        chk({tag, "_inst_rv"}, {63'd0, inst_rv}, 64'd0);
        chk({tag, "_inst_rd"}, {32'd0, inst_rd}, 64'd0);
        chk({tag, "_data_rv"}, {63'd0, data_rv}, 64'd0);
        chk({tag, "_data_rd"}, data_rd, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Waits for a memory request, answers it one cycle later and returns
    // one cycle after the response (the owner's response cycle).
    task automatic serve(input logic [63:0] rdata, output logic [63:0] addr,
                         output logic we, output int icyc, output int mcyc);
        bit seen;
        seen = 1'b0;
        addr = '0;
        we = 1'b0;
        icyc = -1;
        mcyc = -1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (m_valid) begin
                seen = 1'b1;
                addr = m_addr;
                we = m_we;
                icyc = cyc;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL serve_timeout: o_m_valid got 0, expected 1 within 20 cycles");
        end else begin
            @(posedge clk);
            #1;
            m_v = 1'b1;
            m_rdata = rdata;
            mcyc = cyc;
            @(posedge clk);
            #1;
            m_v = 1'b0;
            $display("txn: issue addr=%h we=%0d at cycle %0d, mem response at cycle %0d",
                     addr, we, icyc, mcyc);
        end
    endtask

    task automatic pulse(input logic iv, input logic [63:0] ia, input logic dv,
                         input logic [63:0] da);
        inst_v = iv;
        inst_a = ia;
        data_v = dv;
        data_we = 1'b0;
        data_a = da;
        data_w = '0;
        @(posedge clk);
        #1;
        inst_v = 1'b0;
        data_v = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        logic        w;
        int          ic, mc, ic1, mc1, extra;
        logic [63:0] exp_addr [4];
        bit          exp_data [4];
        int          n_issue;

`ifdef MEM_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif

        //              iv ia      dv dwe da      dw            mv mr                      e_mv mwe ma    mw            irv ird           drv drd                     busy err
        vecs[0]  = '{1, 64'h10, 0, 0, 64'h0,   64'h0,        0, 64'h0,                  0, 0, 64'h0,   64'h0,        0, 32'h0,        0, 64'h0,                  0, 0};
        vecs[1]  = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  0, 0, 64'h0,   64'h0,        0, 32'h0,        0, 64'h0,                  1, 0};
        vecs[2]  = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  1, 0, 64'h10,  64'h0,        0, 32'h0,        0, 64'h0,                  1, 0};
        vecs[3]  = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        1, 64'h00A00093,           0, 0, 64'h10,  64'h0,        0, 32'h0,        0, 64'h0,                  1, 0};
        vecs[4]  = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  0, 0, 64'h10,  64'h0,        1, 32'h00A00093, 0, 64'h0,                  1, 0};
        vecs[5]  = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  0, 0, 64'h10,  64'h0,        0, 32'h00A00093, 0, 64'h0,                  0, 0};
        vecs[6]  = '{0, 64'h0,  1, 1, 64'h200, 64'hDEADBEEF, 0, 64'h0,                  0, 0, 64'h10,  64'h0,        0, 32'h00A00093, 0, 64'h0,                  0, 0};
        vecs[7]  = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  0, 0, 64'h10,  64'h0,        0, 32'h00A00093, 0, 64'h0,                  1, 0};
        vecs[8]  = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  1, 1, 64'h200, 64'hDEADBEEF, 0, 32'h00A00093, 0, 64'h0,                  1, 0};
        vecs[9]  = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        1, 64'h55,                 0, 1, 64'h200, 64'hDEADBEEF, 0, 32'h00A00093, 0, 64'h0,                  1, 0};
        vecs[10] = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  0, 1, 64'h200, 64'hDEADBEEF, 0, 32'h00A00093, 1, 64'h0,                  1, 0};
        vecs[11] = '{0, 64'h0,  1, 0, 64'h300, 64'h0,        0, 64'h0,                  0, 1, 64'h200, 64'hDEADBEEF, 0, 32'h00A00093, 0, 64'h0,                  0, 0};
        vecs[12] = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  0, 1, 64'h200, 64'hDEADBEEF, 0, 32'h00A00093, 0, 64'h0,                  1, 0};
        vecs[13] = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  1, 0, 64'h300, 64'h0,        0, 32'h00A00093, 0, 64'h0,                  1, 0};
        vecs[14] = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  0, 0, 64'h300, 64'h0,        0, 32'h00A00093, 0, 64'h0,                  1, 0};
        vecs[15] = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        1, 64'h0123456789ABCDEF,   0, 0, 64'h300, 64'h0,        0, 32'h00A00093, 0, 64'h0,                  1, 0};
        vecs[16] = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  0, 0, 64'h300, 64'h0,        0, 32'h00A00093, 1, 64'h0123456789ABCDEF,  1, 0};
        vecs[17] = '{0, 64'h0,  0, 0, 64'h0,   64'h0,        0, 64'h0,                  0, 0, 64'h300, 64'h0,        0, 32'h00A00093, 0, 64'h0123456789ABCDEF,  0, 0};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #1;
        rst = 1'b0;

        // Tests 1 and 4 plus a load: outputs checked first, then the cycle's inputs driven
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_m_valid", i), {63'd0, m_valid}, {63'd0, vecs[i].e_mv});
            chk($sformatf("v%0d_m_we", i), {63'd0, m_we}, {63'd0, vecs[i].e_mwe});
            chk($sformatf("v%0d_m_addr", i), m_addr, vecs[i].e_ma);
            chk($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].e_mw);
            chk($sformatf("v%0d_inst_rv", i), {63'd0, inst_rv}, {63'd0, vecs[i].e_irv});
            chk($sformatf("v%0d_inst_rd", i), {32'd0, inst_rd}, {32'd0, vecs[i].e_ird});
            chk($sformatf("v%0d_data_rv", i), {63'd0, data_rv}, {63'd0, vecs[i].e_drv});
            chk($sformatf("v%0d_data_rd", i), data_rd, vecs[i].e_drd);
            chk($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, vecs[i].e_err});
            $display("txn: vector %0d m_valid=%0d addr=%h inst_rv=%0d data_rv=%0d",
                     i, m_valid, m_addr, inst_rv, data_rv);
            inst_v  = vecs[i].iv;
            inst_a  = vecs[i].ia;
            data_v  = vecs[i].dv;
            data_we = vecs[i].dwe;
            data_a  = vecs[i].da;
            data_w  = vecs[i].dw;
            m_v     = vecs[i].mv;
            m_rdata = vecs[i].mr;
        end
        inst_v = 1'b0;
        data_v = 1'b0;
        m_v = 1'b0;

        // Fresh reset so the next tie is the first one after reset
        do_reset();

        // Test 2: simultaneous fetch and load, load wins the first tie
        pulse(1'b1, 64'h40, 1'b1, 64'h100);
        serve(64'h1111_2222_3333_4444, a, w, ic1, mc1);
        chk("t2_first_addr", a, 64'h100);
        chk("t2_first_we", {63'd0, w}, 64'd0);
        chk("t2_first_latency", 64'(ic1 - mc1 + 1), 64'd0);
        chk("t2_load_rv", {63'd0, data_rv}, 64'd1);
        chk("t2_load_inst_rv", {63'd0, inst_rv}, 64'd0);
        chk("t2_load_rd", data_rd, 64'h1111_2222_3333_4444);
        serve(64'h0000_0000_0000_0013, a, w, ic, mc);
        chk("t2_second_addr", a, 64'h40);
        chk("t2_second_issue_cycle", 64'(ic - mc1), 64'd3);
        chk("t2_fetch_rv", {63'd0, inst_rv}, 64'd1);
        chk("t2_fetch_data_rv", {63'd0, data_rv}, 64'd0);
        chk("t2_fetch_rd", {32'd0, inst_rd}, 64'h13);
        @(posedge clk);
        #1;

        // Test 3: consecutive ties with slots refilled during the response cycle
        if (rr) begin
            exp_addr[0] = 64'h500; exp_data[0] = 1'b1;
            exp_addr[1] = 64'h600; exp_data[1] = 1'b0;
            exp_addr[2] = 64'h510; exp_data[2] = 1'b1;
            exp_addr[3] = 64'h610; exp_data[3] = 1'b0;
            n_issue = 4;
        end else begin
            exp_addr[0] = 64'h500; exp_data[0] = 1'b1;
            exp_addr[1] = 64'h510; exp_data[1] = 1'b1;
            exp_addr[2] = 64'h600; exp_data[2] = 1'b0;
            exp_addr[3] = 64'h0;   exp_data[3] = 1'b0;
            n_issue = 3;
        end
        pulse(1'b1, 64'h600, 1'b1, 64'h500);
        for (int k = 0; k < n_issue; k++) begin
            serve(64'hA0 + 64'(k), a, w, ic, mc);
            chk($sformatf("t3_issue%0d_addr", k), a, exp_addr[k]);
            chk($sformatf("t3_issue%0d_data_rv", k), {63'd0, data_rv}, {63'd0, exp_data[k]});
            chk($sformatf("t3_issue%0d_inst_rv", k), {63'd0, inst_rv}, {63'd0, !exp_data[k]});
            if (k == 0) pulse(1'b0, 64'h0, 1'b1, 64'h510);
            else if (k == 1 && rr) pulse(1'b1, 64'h610, 1'b0, 64'h0);
        end
        @(posedge clk);
        #1;
        chk("t3_err", {63'd0, err}, 64'd0);
        chk("t3_busy", {63'd0, busy}, 64'd0);

        // Test 5: second fetch pulse while the first is waiting on memory
        pulse(1'b1, 64'h700, 1'b0, 64'h0);
        extra = 0;
        for (int k = 0; k < 20 && !m_valid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_first_issue", {63'd0, m_valid}, 64'd1);
        chk("t5_first_addr", m_addr, 64'h700);
        @(posedge clk);
        #1;
        inst_v = 1'b1;
        inst_a = 64'h800;
        @(posedge clk);
        #1;
        inst_v = 1'b0;
        chk("t5_err_set", {63'd0, err}, 64'd1);
        m_v = 1'b1;
        m_rdata = 64'h00000000_FEEDF00D;
        @(posedge clk);
        #1;
        m_v = 1'b0;
        chk("t5_fetch_rv", {63'd0, inst_rv}, 64'd1);
        chk("t5_fetch_rd", {32'd0, inst_rd}, 64'hFEEDF00D);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (m_valid) extra++;
        end
        chk("t5_extra_issue", 64'(extra), 64'd0);
        chk("t5_err_sticky", {63'd0, err}, 64'd1);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        $display("txn: dropped fetch 0x800, extra issues %0d", extra);

        // Test 6: reset while waiting on memory, then a clean fetch
        pulse(1'b1, 64'h900, 1'b0, 64'h0);
        for (int k = 0; k < 20 && !m_valid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_issue_addr", m_addr, 64'h900);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("t6_in_reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        pulse(1'b1, 64'hA00, 1'b0, 64'h0);
        serve(64'h0000_0000_0000_0093, a, w, ic, mc);
        chk("t6_new_addr", a, 64'hA00);
        chk("t6_new_rv", {63'd0, inst_rv}, 64'd1);
        chk("t6_new_rd", {32'd0, inst_rd}, 64'h93);
        chk("t6_err", {63'd0, err}, 64'd0);
        @(posedge clk);
        #1;

        // Memory response outside WAIT is ignored but flagged
        m_v = 1'b1;
        m_rdata = 64'hBAD;
        @(posedge clk);
        #1;
        m_v = 1'b0;
        chk("stray_err", {63'd0, err}, 64'd1);
        chk("stray_inst_rv", {63'd0, inst_rv}, 64'd0);
        chk("stray_data_rv", {63'd0, data_rv}, 64'd0);
        chk("stray_busy", {63'd0, busy}, 64'd0);
        $display("txn: stray memory response in IDLE, err=%0d", err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
